// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
// State codes are fixed so RUN is the all-zero reset value.
package hazard_pkg;

   localparam int REG_AW_DEF = 5;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;

   typedef enum logic [1:0] {
      S_RUN  = ST_RUN,
      S_HOLD = ST_HOLD
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// It sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: covers the hazards forwarding cannot
// (load results, ALU results needed by the ID-stage branch comparator).
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] IF_ID_r1,
   input  logic [REG_AW-1:0] IF_ID_r2,
   input  logic              IF_ID_uses_r2,
   input  logic              IF_ID_branch,
   input  logic              IF_ID_jump,
   input  logic              branch_taken,
   input  logic [REG_AW-1:0] ID_EX_RegRd,
   input  logic              ID_EX_RegWrite,
   input  logic              ID_EX_MemRead,
   input  logic [REG_AW-1:0] EX_MEM_RegRd,
   input  logic              EX_MEM_MemRead,
   output logic              PCWrite,
   output logic              IF_ID_Write,
   output logic              IF_ID_Flush,
   output logic              ID_EX_Bubble,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   state_e r_state;
   state_e w_nextState;

   logic w_mE1, w_mE2, w_mM1, w_mM2;
   logic w_exMatch, w_memMatch;
   logic w_hLu, w_hBa, w_hBl2, w_hBl1;
   logic w_stall;
   logic w_stallInc, w_flushInc;

   // x0 is hardwired to zero, so a destination of 0 never creates a dependency.
   assign w_mE1 = (ID_EX_RegRd != '0) && (ID_EX_RegRd == IF_ID_r1);
   assign w_mE2 = (ID_EX_RegRd != '0) && IF_ID_uses_r2 && (ID_EX_RegRd == IF_ID_r2);
   assign w_mM1 = (EX_MEM_RegRd != '0) && (EX_MEM_RegRd == IF_ID_r1);
   assign w_mM2 = (EX_MEM_RegRd != '0) && IF_ID_uses_r2 && (EX_MEM_RegRd == IF_ID_r2);

   assign w_exMatch  = w_mE1 | w_mE2;
   assign w_memMatch = w_mM1 | w_mM2;

   assign w_hLu  = ID_EX_MemRead & w_exMatch;
   assign w_hBa  = IF_ID_branch & ID_EX_RegWrite & ~ID_EX_MemRead & w_exMatch;
   assign w_hBl2 = IF_ID_branch & ID_EX_MemRead & w_exMatch;
   assign w_hBl1 = IF_ID_branch & EX_MEM_MemRead & w_memMatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // HOLD supplies the second stall of a branch waiting on a load still in EX.
   always_comb begin
      w_nextState = S_RUN;
      w_stall     = 1'b0;
      case (r_state)
         S_RUN: begin
            w_stall = w_hLu | w_hBa | w_hBl2 | w_hBl1;
            if (w_hBl2) begin
               w_nextState = S_HOLD;
            end
         end
         S_HOLD: begin
            w_stall = 1'b1;
         end
         default: begin
            w_nextState = S_RUN;
         end
      endcase
   end

   // Stall wins over flush: the comparator result is stale while stalled.
   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      if (rst) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (w_stall) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else begin
         IF_ID_Flush = IF_ID_jump | (IF_ID_branch & branch_taken);
      end
   end

   assign w_stallInc = w_stall & ~rst;
   assign w_flushInc = IF_ID_Flush & ~rst;

   sat_counter #(.W(CNT_W)) u_stallCnt (
      .clk (clk),
      .rst (rst),
      .inc (w_stallInc),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flushCnt (
      .clk (clk),
      .rst (rst),
      .inc (w_flushInc),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed pipeline scenarios then random
// traffic, compared against a stall-budget model; a CNT_W=2 copy checks saturation.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] IF_ID_r1, IF_ID_r2, ID_EX_RegRd, EX_MEM_RegRd;
   logic       IF_ID_uses_r2, IF_ID_branch, IF_ID_jump, branch_taken;
   logic       ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead;

   logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
   logic [31:0] stall_cnt, flush_cnt;
   logic        sPCWrite, sIF_ID_Write, sIF_ID_Flush, sID_EX_Bubble;
   logic [1:0]  sStallCnt, sFlushCnt;

   int compared   = 0;
   int mismatched = 0;

   int     pendingStalls = 0;
   longint modelStalls   = 0;
   longint modelFlushes  = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2), .IF_ID_uses_r2(IF_ID_uses_r2),
      .IF_ID_branch(IF_ID_branch), .IF_ID_jump(IF_ID_jump), .branch_taken(branch_taken),
      .ID_EX_RegRd(ID_EX_RegRd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
      .EX_MEM_RegRd(EX_MEM_RegRd), .EX_MEM_MemRead(EX_MEM_MemRead),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Bubble(ID_EX_Bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_stall_ctrl #(.REG_AW(5), .CNT_W(2)) dutSmall (
      .clk(clk), .rst(rst),
      .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2), .IF_ID_uses_r2(IF_ID_uses_r2),
      .IF_ID_branch(IF_ID_branch), .IF_ID_jump(IF_ID_jump), .branch_taken(branch_taken),
      .ID_EX_RegRd(ID_EX_RegRd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
      .EX_MEM_RegRd(EX_MEM_RegRd), .EX_MEM_MemRead(EX_MEM_MemRead),
      .PCWrite(sPCWrite), .IF_ID_Write(sIF_ID_Write), .IF_ID_Flush(sIF_ID_Flush),
      .ID_EX_Bubble(sID_EX_Bubble), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input int r1, input int r2, input bit usesR2,
                                input bit br, input bit jmp, input bit taken,
                                input int exRd, input bit exWr, input bit exLd,
                                input int memRd, input bit memLd);
      rst            = r;
      IF_ID_r1       = 5'(r1);
      IF_ID_r2       = 5'(r2);
      IF_ID_uses_r2  = usesR2;
      IF_ID_branch   = br;
      IF_ID_jump     = jmp;
      branch_taken   = taken;
      ID_EX_RegRd    = 5'(exRd);
      ID_EX_RegWrite = exWr;
      ID_EX_MemRead  = exLd;
      EX_MEM_RegRd   = 5'(memRd);
      EX_MEM_MemRead = exLd ? memLd : memLd;
   endtask

   // Number of stall cycles the ID instruction needs before its operands are usable.
   function automatic int stallsNeeded();
      int  srcs[$];
      bit  inEx, inMem;
      int  need;
      srcs.push_back(int'(IF_ID_r1));
      if (IF_ID_uses_r2) srcs.push_back(int'(IF_ID_r2));
      inEx  = 0;
      inMem = 0;
      foreach (srcs[k]) begin
         if (srcs[k] != 0 && srcs[k] == int'(ID_EX_RegRd))  inEx  = 1;
         if (srcs[k] != 0 && srcs[k] == int'(EX_MEM_RegRd)) inMem = 1;
      end
      need = 0;
      if (inEx && ID_EX_MemRead)                    need = IF_ID_branch ? 2 : 1;
      else if (inEx && IF_ID_branch && ID_EX_RegWrite) need = 1;
      if (IF_ID_branch && EX_MEM_MemRead && inMem && need < 1) need = 1;
      return need;
   endfunction

   function automatic longint sat3(input longint v);
      return (v > 3) ? 3 : v;
   endfunction

   // Check one cycle against the model, then advance through the clock edge.
   task automatic step(input string tag);
      bit expStall, expFlush;
      int nextPending;
      #1;
      expStall    = 0;
      expFlush    = 0;
      nextPending = 0;
      if (!rst) begin
         if (pendingStalls > 0) begin
            expStall    = 1;
            nextPending = pendingStalls - 1;
         end else begin
            int need;
            need        = stallsNeeded();
            expStall    = (need > 0);
            nextPending = (need > 0) ? need - 1 : 0;
         end
         expFlush = !expStall && (IF_ID_jump || (IF_ID_branch && branch_taken));
      end
      checkOutput({tag, ".PCWrite"},     64'(PCWrite),      rst ? 64'd0 : 64'(!expStall));
      checkOutput({tag, ".IF_ID_Write"}, 64'(IF_ID_Write),  rst ? 64'd0 : 64'(!expStall));
      checkOutput({tag, ".IF_ID_Flush"}, 64'(IF_ID_Flush),  rst ? 64'd1 : 64'(expFlush));
      checkOutput({tag, ".ID_EX_Bubble"},64'(ID_EX_Bubble), rst ? 64'd1 : 64'(expStall));
      checkOutput({tag, ".stall_cnt"},   64'(stall_cnt),    64'(modelStalls));
      checkOutput({tag, ".flush_cnt"},   64'(flush_cnt),    64'(modelFlushes));
      checkOutput({tag, ".small_stall"}, 64'(sStallCnt),    64'(sat3(modelStalls)));
      checkOutput({tag, ".small_flush"}, 64'(sFlushCnt),    64'(sat3(modelFlushes)));
      @(posedge clk);
      if (rst) begin
         pendingStalls = 0;
         modelStalls   = 0;
         modelFlushes  = 0;
      end else begin
         pendingStalls = nextPending;
         if (expStall) modelStalls++;
         if (expFlush) modelFlushes++;
      end
      @(negedge clk);
   endtask

   task automatic resetDut();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset");
   endtask

   task automatic idle(input string tag);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(tag);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      resetDut();
      checkOutput("rst.stall_cnt0", 64'(stall_cnt), 64'd0);

      // lw x5 in EX, add x6,x5,x7 in ID
      applyStimulus(0, 5, 7, 1, 0, 0, 0, 5, 1, 1, 0, 0);
      step("t1.stall");
      applyStimulus(0, 5, 7, 1, 0, 0, 0, 0, 0, 0, 5, 1);
      step("t1.go");
      checkOutput("t1.cnt", 64'(stall_cnt), 64'd1);

      // add x5 in EX, beq x5,x0 in ID; then taken with x5 in MEM
      resetDut();
      applyStimulus(0, 5, 0, 1, 1, 0, 0, 5, 1, 0, 0, 0);
      step("t2.stall");
      applyStimulus(0, 5, 0, 1, 1, 0, 1, 0, 0, 0, 5, 0);
      step("t2.flush");
      checkOutput("t2.fcnt", 64'(flush_cnt), 64'd1);

      // lw x5 in EX, bne x5,x1 in ID: two stalls whatever the second-cycle inputs
      resetDut();
      applyStimulus(0, 5, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
      step("t3.s1");
      applyStimulus(0, 9, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      step("t3.s2");
      idle("t3.run");
      checkOutput("t3.cnt", 64'(stall_cnt), 64'd2);

      // rd=0 everywhere, ID reads x0; then jal
      resetDut();
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1);
      step("t4.x0");
      applyStimulus(0, 3, 4, 0, 0, 1, 0, 8, 1, 0, 9, 0);
      step("t4.jal");
      idle("t4.after");

      // reset while in HOLD
      resetDut();
      applyStimulus(0, 5, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
      step("t5.s1");
      applyStimulus(1, 5, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
      step("t5.rst");
      idle("t5.run");
      checkOutput("t5.cnt", 64'(stall_cnt), 64'd0);

      // five load-use stalls: narrow counter saturates at 3
      resetDut();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 6, 2, 0, 0, 0, 0, 6, 1, 1, 0, 0);
         step("t6.lu");
      end
      checkOutput("t6.small", 64'(sStallCnt), 64'd3);
      checkOutput("t6.wide",  64'(stall_cnt), 64'd5);

      // random traffic on a small register window so hazards are frequent
      resetDut();
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 39) == 0),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom));
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
